env_gate_ctrl: RTL and testbench
================================

# env_gate_ctrl

Envelope gate controller: the driving end of the synth's right-shift envelope interface. It converts a key-on level into the master enable (`en1`) and rate-limited step strobe (`en2`) the envelope shifter consumes. It monitors the shifter's `hold` and `z_flg` returns to sequence attack, decay/sustain and release. It also produces `voice_en` for the frequency controller and ROM address counter.

## Interface
Parameters:
- `RW`, 16, width of the rate registers and prescaler counter.

Ports:
- `CLK` in 1: single system clock, rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `key_on` in 1: note key level, synchronous to `CLK`; 1 means held.
- `attack_rate` in RW: cycles per `en2` strobe during ATTACK; 0 is treated as 1.
- `decay_rate` in RW: cycles per `en2` strobe during DECAY; 0 is treated as 1.
- `hold_in` in 1: shifter `hold` return.
- `z_flg_in` in 1: shifter `z_flg` return; attack peak reached.
- `en1` out 1: master enable to the shifter (shifter EN1).
- `en2` out 1: one-cycle step strobe to the shifter (shifter EN2).
- `voice_en` out 1: oscillator/ROM run enable.
- `state` out 2: current state (IDLE=0, ATTACK=1, DECAY=2, RELEASE=3).
- `step_cnt` out 8: `en2` strobes issued since the last ATTACK entry, saturating at 255.

## Operation
- All outputs are registered. Reset values: `state`=IDLE, `en1`=0, `en2`=0, `voice_en`=0, `step_cnt`=0, prescaler=0, `key_q`=0.
- Edge detect: `key_q` holds the previous value of `key_on`. `key_rise` = `key_on & ~key_q`.
- IDLE:
  - `en1`=0, `en2`=0.
  - On `key_rise`, go to ATTACK.
- ATTACK:
  - `en1`=1. Latch `attack_rate` on entry.
  - If `key_on`=0, go to RELEASE (highest priority).
  - Else if `z_flg_in`=1, go to DECAY.
- DECAY (sustain is implicit):
  - `en1`=1. Latch `decay_rate` on entry.
  - `en2` keeps strobing; the shifter stops itself at its D_S parameter.
  - If `key_on`=0, go to RELEASE.
- RELEASE:
  - `en1`=0, `en2`=0. The shifter decrements once per clock on its own.
  - On `key_rise`, retrigger: go to ATTACK. This has priority over the `hold_in` check.
  - Else if `hold_in`=0, go to IDLE.
- Prescaler:
  - Clear `cnt` on every state entry.
  - In ATTACK or DECAY, `cnt` increments each cycle.
  - When `cnt` = latched_rate−1, `en2` pulses for one cycle and `cnt` returns to 0.
  - A latched rate of 0 or 1 gives `en2`=1 on every cycle.
  - Rate inputs are sampled only at state entry; changes mid-phase take effect at the next phase.
- `step_cnt`:
  - Cleared on ATTACK entry, including retrigger.
  - Incremented on each `en2` pulse; saturates at 255.
- `voice_en` = (next state ≠ IDLE) | `hold_in`, registered.
- Retrigger while the shifter's `z_flg` is still set: the controller enters ATTACK, sees `z_flg_in`=1 and moves to DECAY on the next cycle. This is legal and required; the shifter resumes from its current total.
- `key_on` held high while in IDLE with no rise (e.g. high out of reset): stay in IDLE.

## Timing
- `key_rise` sampled at edge k: `state`=ATTACK and `en1`=1 after edge k. Latency is 1 cycle from `key_on` rising.
- First `en2` after entering ATTACK/DECAY: asserted R cycles after the entry edge, where R = latched rate (min 1). Subsequent pulses every R cycles.
- `key_on` falling sampled at edge k: `en1`=0 and `state`=RELEASE after edge k. No `en2` is asserted after edge k.
- `hold_in` low sampled at edge k in RELEASE: IDLE and `voice_en`=0 after edge k.
- `z_flg_in` high at edge k in ATTACK: DECAY after edge k, and the prescaler restarts.
- Reset asserted mid-phase: all outputs go to their reset values immediately (asynchronous). Deassertion is synchronized to `CLK` by the system reset bridge.

## Structure
- Shared package `env_pkg`:
  - `env_state_t` enum (IDLE, ATTACK, DECAY, RELEASE).
  - Constant `ENV_RW`=16.
  - Constant `ENV_STEP_W`=8.
- Sub-module `rate_prescaler`:
  - Ports: clear, enable, rate, strobe.
  - Holds the latched rate and down/up counter.
  - Instanced once; FSM and edge detect live in the top.

## Test plan
Bench uses a behavioral shifter model: on each `en2` step it increments total, and raises `z_flg` on the step where total=16 (17 steps).
- Reset mid-ATTACK, `RST_N` low for 3 cycles → all outputs 0 asynchronously; IDLE after release; a new `key_rise` is required to restart.
- `attack_rate`=4, `decay_rate`=8, `key_on` rises at cycle 10 → `en1` high at cycle 11; `en2` every 4 cycles; DECAY entered after 17 strobes; then `en2` every 8 cycles.
- `key_on` falls during DECAY → `en1`=0 next cycle, no further `en2`; shifter drains; `hold_in` falls → IDLE, `voice_en`=0.
- `key_on` falls after 5 ATTACK strobes → RELEASE directly from ATTACK, `step_cnt`=5.
- Retrigger in RELEASE with the model's `z_flg` still set → ATTACK for exactly 1 cycle, then DECAY; `step_cnt` cleared.
- `attack_rate`=0 → `en2` high every cycle in ATTACK, `z_flg_in` after 17 cycles; `step_cnt` saturates at 255 over a long DECAY with `decay_rate`=1.

Source files
------------

// File: rtl/env_pkg.sv
// env_pkg: shared state encoding and widths for the envelope gate controller.
package env_pkg;
  localparam int ENV_RW = 16;
  localparam int ENV_STEP_W = 8;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    DECAY   = 2'd2,
    RELEASE = 2'd3
  } env_state_t;
  function automatic logic is_active(input env_state_t s);
    return (s == ATTACK) || (s == DECAY);
  endfunction
endpackage

// File: rtl/rate_prescaler.sv
// rate_prescaler: latches a step rate on clear and emits a registered strobe every rate cycles.
module rate_prescaler
  import env_pkg::*;
#(
  parameter int RW = ENV_RW
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          clear,
  input  logic          enable,
  input  logic [RW-1:0] rate,
  output logic          strobe
);
  logic [RW-1:0] rate_m1;
  logic [RW-1:0] cnt;
  logic          last;
  assign last = cnt == rate_m1;
  // rate is stored minus one so that 0 and 1 both give a strobe every cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rate_m1 <= '0;
      cnt     <= '0;
      strobe  <= 1'b0;
    end else if (clear) begin
      rate_m1 <= (rate == '0) ? '0 : rate - RW'(1);
      cnt     <= '0;
      strobe  <= 1'b0;
    end else begin
      strobe <= enable && last;
      cnt    <= (enable && !last) ? cnt + RW'(1) : '0;
    end
  end
endmodule

// File: rtl/env_gate_ctrl.sv
// env_gate_ctrl: key-driven ADSR sequencer producing the shifter enables and the voice run enable.
module env_gate_ctrl
  import env_pkg::*;
#(
  parameter int RW = ENV_RW
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  key_on,
  input  logic [RW-1:0]         attack_rate,
  input  logic [RW-1:0]         decay_rate,
  input  logic                  hold_in,
  input  logic                  z_flg_in,
  output logic                  en1,
  output logic                  en2,
  output logic                  voice_en,
  output logic [1:0]            state,
  output logic [ENV_STEP_W-1:0] step_cnt
);
  env_state_t st, nxt;
  logic       key_q;
  logic       key_rise;
  logic       enter;
  assign key_rise = key_on & ~key_q;
  assign enter    = nxt != st;
  assign state    = st;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = key_rise ? ATTACK : IDLE;
      ATTACK:  nxt = !key_on ? RELEASE : z_flg_in ? DECAY : ATTACK;
      DECAY:   nxt = !key_on ? RELEASE : DECAY;
      RELEASE: nxt = key_rise ? ATTACK : !hold_in ? IDLE : RELEASE;
      default: nxt = IDLE;
    endcase
  end
  // rate mux looks at the next state so the entering phase latches its own rate
  rate_prescaler #(.RW(RW)) u_pre (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clear (enter),
    .enable(is_active(st)),
    .rate  ((nxt == ATTACK) ? attack_rate : decay_rate),
    .strobe(en2)
  );
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st       <= IDLE;
      key_q    <= 1'b0;
      en1      <= 1'b0;
      voice_en <= 1'b0;
      step_cnt <= '0;
    end else begin
      st       <= nxt;
      key_q    <= key_on;
      en1      <= is_active(nxt);
      voice_en <= (nxt != IDLE) | hold_in;
      step_cnt <= (enter && nxt == ATTACK) ? '0 :
                  (en2 && step_cnt != '1) ? step_cnt + ENV_STEP_W'(1) : step_cnt;
    end
  end
endmodule

// File: tb/tb_env_gate_ctrl.sv
// tb_env_gate_ctrl: directed checks of env_gate_ctrl against a behavioral shifter model.
module tb_env_gate_ctrl;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        key_on = 1'b0;
  logic [15:0] attack_rate = 16'd4;
  logic [15:0] decay_rate = 16'd8;
  logic        hold_in = 1'b0;
  logic        z_flg_in = 1'b0;
  logic        en1, en2, voice_en;
  logic [1:0]  state;
  logic [7:0]  step_cnt;
  int          n_cmp = 0;
  int          n_err = 0;
  int          total = 0;
  logic        z = 1'b0;

  env_gate_ctrl #(.RW(16)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .key_on     (key_on),
    .attack_rate(attack_rate),
    .decay_rate (decay_rate),
    .hold_in    (hold_in),
    .z_flg_in   (z_flg_in),
    .en1        (en1),
    .en2        (en2),
    .voice_en   (voice_en),
    .state      (state),
    .step_cnt   (step_cnt)
  );

  always #5 CLK = ~CLK;

  // shifter model: counts up to 16 then flags the peak, decays to 8, drains when en1 drops
  always @(negedge CLK) begin
    if (!RST_N) begin
      total = 0;
      z = 1'b0;
    end else if (en1 && en2) begin
      if (!z) begin
        if (total == 16) z = 1'b1;
        else total++;
      end else if (total > 8) total--;
    end else if (!en1 && total != 0) total--;
    if (total == 0) z = 1'b0;
    hold_in  = total != 0;
    z_flg_in = z;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] s, input logic e1, input logic e2,
                         input logic v, input logic [7:0] sc);
    chk({tag, ".state"}, 32'(state), 32'(s));
    chk({tag, ".en1"}, 32'(en1), 32'(e1));
    chk({tag, ".en2"}, 32'(en2), 32'(e2));
    chk({tag, ".voice_en"}, 32'(voice_en), 32'(v));
    chk({tag, ".step_cnt"}, 32'(step_cnt), 32'(sc));
  endtask

  initial begin
    #1;
    chk_all("reset", 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(2);
    RST_N = 1'b1;
    tick(2);
    chk("idle_after_reset", 32'(state), 32'd0);
    // attack 4 / decay 8
    key_on = 1'b1;
    tick(1);
    chk_all("atk_entry", 2'd1, 1'b1, 1'b0, 1'b1, 8'd0);
    tick(4);
    chk_all("atk_first_en2", 2'd1, 1'b1, 1'b1, 1'b1, 8'd0);
    tick(1);
    chk_all("atk_en2_low", 2'd1, 1'b1, 1'b0, 1'b1, 8'd1);
    tick(63);
    chk_all("atk_17th_en2", 2'd1, 1'b1, 1'b1, 1'b1, 8'd16);
    tick(1);
    chk_all("decay_entry", 2'd2, 1'b1, 1'b0, 1'b1, 8'd17);
    tick(7);
    chk("decay_gap", 32'(en2), 32'd0);
    tick(1);
    chk("decay_first_en2", 32'(en2), 32'd1);
    tick(1);
    chk("decay_step", 32'(step_cnt), 32'd18);
    key_on = 1'b0;
    tick(1);
    chk_all("rel_from_decay", 2'd3, 1'b0, 1'b0, 1'b1, 8'd18);
    tick(6);
    chk("rel_no_en2", 32'(en2), 32'd0);
    tick(8);
    chk_all("rel_draining", 2'd3, 1'b0, 1'b0, 1'b1, 8'd18);
    tick(1);
    chk_all("rel_to_idle", 2'd0, 1'b0, 1'b0, 1'b0, 8'd18);
    // release straight from attack after 5 strobes
    key_on = 1'b1;
    tick(1);
    chk("atk2_entry", 32'(state), 32'd1);
    chk("atk2_step_clr", 32'(step_cnt), 32'd0);
    tick(21);
    chk("atk2_5_steps", 32'(step_cnt), 32'd5);
    key_on = 1'b0;
    tick(1);
    chk_all("rel_from_atk", 2'd3, 1'b0, 1'b0, 1'b1, 8'd5);
    tick(2);
    chk("rel_from_atk_no_en2", 32'(en2), 32'd0);
    tick(3);
    chk("rel_from_atk_idle", 32'(state), 32'd0);
    // attack rate 0, decay rate 1, retrigger while peak flag is still set
    attack_rate = 16'd0;
    decay_rate  = 16'd1;
    key_on = 1'b1;
    tick(1);
    chk_all("fast_atk_entry", 2'd1, 1'b1, 1'b0, 1'b1, 8'd0);
    tick(1);
    chk_all("fast_atk_en2", 2'd1, 1'b1, 1'b1, 1'b1, 8'd0);
    tick(16);
    chk_all("fast_atk_17th", 2'd1, 1'b1, 1'b1, 1'b1, 8'd16);
    tick(1);
    chk_all("fast_decay_entry", 2'd2, 1'b1, 1'b0, 1'b1, 8'd17);
    tick(1);
    chk("fast_decay_en2", 32'(en2), 32'd1);
    key_on = 1'b0;
    tick(1);
    chk_all("fast_rel", 2'd3, 1'b0, 1'b0, 1'b1, 8'd18);
    key_on = 1'b1;
    tick(1);
    chk_all("retrig_atk", 2'd1, 1'b1, 1'b0, 1'b1, 8'd0);
    tick(1);
    chk_all("retrig_decay", 2'd2, 1'b1, 1'b0, 1'b1, 8'd0);
    tick(255);
    chk("sat_254", 32'(step_cnt), 32'd254);
    tick(1);
    chk("sat_255", 32'(step_cnt), 32'd255);
    chk("sat_en2", 32'(en2), 32'd1);
    tick(20);
    chk("sat_hold", 32'(step_cnt), 32'd255);
    key_on = 1'b0;
    tick(12);
    chk("sat_idle", 32'(state), 32'd0);
    // asynchronous reset in the middle of attack
    attack_rate = 16'd4;
    key_on = 1'b1;
    tick(10);
    chk_all("pre_rst_atk", 2'd1, 1'b1, 1'b0, 1'b1, 8'd2);
    #2;
    RST_N = 1'b0;
    #1;
    chk_all("async_rst", 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    key_on = 1'b0;
    tick(3);
    chk_all("rst_held", 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    RST_N = 1'b1;
    tick(3);
    chk_all("post_rst_idle", 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    key_on = 1'b1;
    tick(1);
    chk_all("post_rst_restart", 2'd1, 1'b1, 1'b0, 1'b1, 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
